// File: rtl/opfwd_pkg.sv
// Shared definitions for the operand forwarding stage: default widths,
// the hardwired-zero register index and the per-source forward select.
package opfwd_pkg;

    localparam int unsigned OPFWD_DATA_WIDTH = 32;
    localparam int unsigned OPFWD_ADDR_WIDTH = 5;
    localparam int unsigned STALL_CNT_WIDTH  = 32;

    // Register index that always reads as zero
    localparam int unsigned REG_ZERO = 0;

    // Where a source operand is taken from
    typedef enum logic [2:0] {
        FWD_ZERO = 3'd0,
        FWD_EX   = 3'd1,
        FWD_MEM  = 3'd2,
        FWD_WB   = 3'd3,
        FWD_RF   = 3'd4
    } fwd_sel_e;

endpackage : opfwd_pkg

// File: rtl/fwd_mux_sel.sv
// Forward select and data mux for one source operand, plus its load-use flag.
//   iAddr/iEn              captured source index and "source used" flag
//   iRfData                register-file data for that index
//   iEx*/iMem*/iWb*        in-flight results from EX, MEM and WB
//   oFwdData_c             resolved operand (combinational)
//   oLoadUse_c             EX holds a load targeting this used source (combinational)
module fwd_mux_sel
    import opfwd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = OPFWD_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = OPFWD_ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] iAddr,
    input  logic                  iEn,
    input  logic [DATA_WIDTH-1:0] iRfData,
    input  logic                  iExWe,
    input  logic                  iExIsLoad,
    input  logic [ADDR_WIDTH-1:0] iExAddr,
    input  logic [DATA_WIDTH-1:0] iExData,
    input  logic                  iMemWe,
    input  logic [ADDR_WIDTH-1:0] iMemAddr,
    input  logic [DATA_WIDTH-1:0] iMemData,
    input  logic                  iWbWe,
    input  logic [ADDR_WIDTH-1:0] iWbAddr,
    input  logic [DATA_WIDTH-1:0] iWbData,
    output logic [DATA_WIDTH-1:0] oFwdData_c,
    output logic                  oLoadUse_c
);

    fwd_sel_e sel;
    logic     addr_is_zero;
    logic     ex_is_zero;

    assign addr_is_zero = (iAddr   == ADDR_WIDTH'(REG_ZERO));
    assign ex_is_zero   = (iExAddr == ADDR_WIDTH'(REG_ZERO));

    // Youngest producer wins; EX load data is not ready yet so it never forwards
    always_comb begin
        sel = FWD_RF;
        if (addr_is_zero) begin
            sel = FWD_ZERO;
        end else if (iExWe && !iExIsLoad && (iExAddr == iAddr)) begin
            sel = FWD_EX;
        end else if (iMemWe && (iMemAddr == iAddr)) begin
            sel = FWD_MEM;
        end else if (iWbWe && (iWbAddr == iAddr)) begin
            sel = FWD_WB;
        end
    end

    always_comb begin
        oFwdData_c = iRfData;
        case (sel)
            FWD_ZERO: oFwdData_c = '0;
            FWD_EX:   oFwdData_c = iExData;
            FWD_MEM:  oFwdData_c = iMemData;
            FWD_WB:   oFwdData_c = iWbData;
            default:  oFwdData_c = iRfData;
        endcase
    end

    // Unused sources and r0 never stall
    assign oLoadUse_c = iEn && iExWe && iExIsLoad && !ex_is_zero && (iExAddr == iAddr);

endmodule : fwd_mux_sel

// File: rtl/operand_forward_stage.sv
// Operand forwarding stage between the dual-read register file and execute.
// Captures read addresses, muxes register-file data against in-flight
// EX/MEM/WB results, detects load-use hazards and registers operands A/B.
// Optional stall-cycle counter enabled by defining OPFWD_STALL_CNT_EN.
//   iClk, iRst_n            clock, synchronous active-low reset
//   iValid, iAddrRead0/1,
//   iEnRead0/1              decode instruction and its source indices/uses
//   iDataRead0/1            register-file data, one cycle after the address
//   iEx*/iMem*/iWb*         in-flight writer results
//   iHold, iFlush           execute back-pressure, pipeline flush
//   oStall                  upstream must hold (combinational)
//   oValid, oOpA, oOpB      registered operands to execute
//   oStallCnt               stall-cycle count (zero when the counter is disabled)
module operand_forward_stage
    import opfwd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = OPFWD_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = OPFWD_ADDR_WIDTH
) (
    input  logic                       iClk,
    input  logic                       iRst_n,
    input  logic                       iValid,
    input  logic [ADDR_WIDTH-1:0]      iAddrRead0,
    input  logic [ADDR_WIDTH-1:0]      iAddrRead1,
    input  logic                       iEnRead0,
    input  logic                       iEnRead1,
    input  logic [DATA_WIDTH-1:0]      iDataRead0,
    input  logic [DATA_WIDTH-1:0]      iDataRead1,
    input  logic                       iExWe,
    input  logic                       iExIsLoad,
    input  logic [ADDR_WIDTH-1:0]      iExAddr,
    input  logic [DATA_WIDTH-1:0]      iExData,
    input  logic                       iMemWe,
    input  logic [ADDR_WIDTH-1:0]      iMemAddr,
    input  logic [DATA_WIDTH-1:0]      iMemData,
    input  logic                       iWbWe,
    input  logic [ADDR_WIDTH-1:0]      iWbAddr,
    input  logic [DATA_WIDTH-1:0]      iWbData,
    input  logic                       iHold,
    input  logic                       iFlush,
    output logic                       oStall,
    output logic                       oValid,
    output logic [DATA_WIDTH-1:0]      oOpA,
    output logic [DATA_WIDTH-1:0]      oOpB,
    output logic [STALL_CNT_WIDTH-1:0] oStallCnt
);

    // Capture stage registers
    logic                  c_valid_q, c_valid_d;
    logic [ADDR_WIDTH-1:0] c_addr0_q, c_addr0_d;
    logic [ADDR_WIDTH-1:0] c_addr1_q, c_addr1_d;
    logic                  c_en0_q,   c_en0_d;
    logic                  c_en1_q,   c_en1_d;

    // Output registers
    logic                  o_valid_q, o_valid_d;
    logic [DATA_WIDTH-1:0] o_opa_q,   o_opa_d;
    logic [DATA_WIDTH-1:0] o_opb_q,   o_opb_d;

    logic [DATA_WIDTH-1:0] fwd_a_c;
    logic [DATA_WIDTH-1:0] fwd_b_c;
    logic                  load_use0_c;
    logic                  load_use1_c;
    logic                  hazard_c;
    logic                  stall_c;

    fwd_mux_sel #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fwd_a (
        .iAddr      (c_addr0_q),
        .iEn        (c_en0_q),
        .iRfData    (iDataRead0),
        .iExWe      (iExWe),
        .iExIsLoad  (iExIsLoad),
        .iExAddr    (iExAddr),
        .iExData    (iExData),
        .iMemWe     (iMemWe),
        .iMemAddr   (iMemAddr),
        .iMemData   (iMemData),
        .iWbWe      (iWbWe),
        .iWbAddr    (iWbAddr),
        .iWbData    (iWbData),
        .oFwdData_c (fwd_a_c),
        .oLoadUse_c (load_use0_c)
    );

    fwd_mux_sel #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fwd_b (
        .iAddr      (c_addr1_q),
        .iEn        (c_en1_q),
        .iRfData    (iDataRead1),
        .iExWe      (iExWe),
        .iExIsLoad  (iExIsLoad),
        .iExAddr    (iExAddr),
        .iExData    (iExData),
        .iMemWe     (iMemWe),
        .iMemAddr   (iMemAddr),
        .iMemData   (iMemData),
        .iWbWe      (iWbWe),
        .iWbAddr    (iWbAddr),
        .iWbData    (iWbData),
        .oFwdData_c (fwd_b_c),
        .oLoadUse_c (load_use1_c)
    );

    assign hazard_c = c_valid_q && (load_use0_c || load_use1_c);
    assign stall_c  = hazard_c || iHold;
    assign oStall   = stall_c;

    // Capture: a flush forces the edge through even while stalled
    always_comb begin
        c_valid_d = c_valid_q;
        c_addr0_d = c_addr0_q;
        c_addr1_d = c_addr1_q;
        c_en0_d   = c_en0_q;
        c_en1_d   = c_en1_q;
        if (iFlush || !stall_c) begin
            c_valid_d = iValid && !iFlush;
            c_addr0_d = iAddrRead0;
            c_addr1_d = iAddrRead1;
            c_en0_d   = iEnRead0;
            c_en1_d   = iEnRead1;
        end
    end

    // Output: flush > hold > load-use bubble > normal update
    always_comb begin
        o_valid_d = o_valid_q;
        o_opa_d   = o_opa_q;
        o_opb_d   = o_opb_q;
        if (iFlush) begin
            o_valid_d = 1'b0;
        end else if (iHold) begin
            o_valid_d = o_valid_q;
        end else if (hazard_c) begin
            o_valid_d = 1'b0;
        end else begin
            o_valid_d = c_valid_q;
            o_opa_d   = fwd_a_c;
            o_opb_d   = fwd_b_c;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            c_valid_q <= 1'b0;
            c_addr0_q <= '0;
            c_addr1_q <= '0;
            c_en0_q   <= 1'b0;
            c_en1_q   <= 1'b0;
            o_valid_q <= 1'b0;
            o_opa_q   <= '0;
            o_opb_q   <= '0;
        end else begin
            c_valid_q <= c_valid_d;
            c_addr0_q <= c_addr0_d;
            c_addr1_q <= c_addr1_d;
            c_en0_q   <= c_en0_d;
            c_en1_q   <= c_en1_d;
            o_valid_q <= o_valid_d;
            o_opa_q   <= o_opa_d;
            o_opb_q   <= o_opb_d;
        end
    end

    assign oValid = o_valid_q;
    assign oOpA   = o_opa_q;
    assign oOpB   = o_opb_q;

`ifdef OPFWD_STALL_CNT_EN
    // Free-running stall counter, wraps naturally
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_c) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign oStallCnt = stall_cnt_q;
`else
    assign oStallCnt = '0;
`endif

endmodule : operand_forward_stage

// File: tb/tb_operand_forward_stage.sv
// Directed bench for operand_forward_stage with a queue-based scoreboard.
module tb_operand_forward_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

`ifdef OPFWD_STALL_CNT_EN
    localparam logic [31:0] STALL_EXP = 32'd5;
`else
    localparam logic [31:0] STALL_EXP = 32'd0;
`endif

    logic          iClk = 1'b0;
    logic          iRst_n;
    logic          iValid;
    logic [AW-1:0] iAddrRead0, iAddrRead1;
    logic          iEnRead0, iEnRead1;
    logic [DW-1:0] iDataRead0, iDataRead1;
    logic          iExWe, iExIsLoad;
    logic [AW-1:0] iExAddr;
    logic [DW-1:0] iExData;
    logic          iMemWe;
    logic [AW-1:0] iMemAddr;
    logic [DW-1:0] iMemData;
    logic          iWbWe;
    logic [AW-1:0] iWbAddr;
    logic [DW-1:0] iWbData;
    logic          iHold, iFlush;
    logic          oStall, oValid;
    logic [DW-1:0] oOpA, oOpB;
    logic [31:0]   oStallCnt;

    always #5 iClk = ~iClk;

    operand_forward_stage #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .iClk       (iClk),
        .iRst_n     (iRst_n),
        .iValid     (iValid),
        .iAddrRead0 (iAddrRead0),
        .iAddrRead1 (iAddrRead1),
        .iEnRead0   (iEnRead0),
        .iEnRead1   (iEnRead1),
        .iDataRead0 (iDataRead0),
        .iDataRead1 (iDataRead1),
        .iExWe      (iExWe),
        .iExIsLoad  (iExIsLoad),
        .iExAddr    (iExAddr),
        .iExData    (iExData),
        .iMemWe     (iMemWe),
        .iMemAddr   (iMemAddr),
        .iMemData   (iMemData),
        .iWbWe      (iWbWe),
        .iWbAddr    (iWbAddr),
        .iWbData    (iWbData),
        .iHold      (iHold),
        .iFlush     (iFlush),
        .oStall     (oStall),
        .oValid     (oValid),
        .oOpA       (oOpA),
        .oOpB       (oOpB),
        .oStallCnt  (oStallCnt)
    );

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic clr_wr();
        iExWe = 1'b0; iExIsLoad = 1'b0; iExAddr = '0; iExData = '0;
        iMemWe = 1'b0; iMemAddr = '0; iMemData = '0;
        iWbWe = 1'b0; iWbAddr = '0; iWbData = '0;
    endtask

    task automatic issue(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic e0, input logic e1);
        iValid = 1'b1;
        iAddrRead0 = a0; iAddrRead1 = a1;
        iEnRead0 = e0;   iEnRead1 = e1;
    endtask

    task automatic none();
        iValid = 1'b0;
    endtask

    // Source A = r5 with selectable EX/MEM/WB writers all targeting r5
    task automatic prio(input logic ex, input logic mem, input logic wb, input logic [DW-1:0] exp_a);
        issue(5'd5, 5'd0, 1'b1, 1'b0);
        step();
        none();
        iExWe  = ex;  iExIsLoad = 1'b0; iExAddr = 5'd5; iExData = 32'hAA;
        iMemWe = mem; iMemAddr = 5'd5; iMemData = 32'hBB;
        iWbWe  = wb;  iWbAddr = 5'd5;  iWbData = 32'hCC;
        iDataRead0 = 32'h55; iDataRead1 = 32'h99;
        push(exp_a, 32'h0);
        step();
        clr_wr();
        iDataRead0 = '0; iDataRead1 = '0;
    endtask

    // Monitor: execute accepts whenever oValid is high and it is not holding
    initial begin
        exp_t e;
        forever begin
            @(negedge iClk);
            if (oValid === 1'b1 && iHold === 1'b0) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_valid: got A=0x%08h B=0x%08h, expected no output", oOpA, oOpB);
                end else begin
                    e = sb_q.pop_front();
                    check("opA", oOpA, e.a);
                    check("opB", oOpB, e.b);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        iRst_n = 1'b0; iValid = 1'b0; iAddrRead0 = '0; iAddrRead1 = '0;
        iEnRead0 = 1'b0; iEnRead1 = 1'b0; iDataRead0 = '0; iDataRead1 = '0;
        iHold = 1'b0; iFlush = 1'b0;
        clr_wr();
        step();
        step();
        check("rst_valid", 32'(oValid), 32'd0);
        check("rst_opA", oOpA, 32'd0);
        check("rst_opB", oOpB, 32'd0);
        check("rst_stall", 32'(oStall), 32'd0);
        check("rst_cnt", oStallCnt, 32'd0);
        iRst_n = 1'b1;

        // No hazard: plain register-file read, two-cycle latency
        issue(5'd3, 5'd4, 1'b1, 1'b1);
        step();
        none();
        iDataRead0 = 32'h11; iDataRead1 = 32'h22;
        push(32'h11, 32'h22);
        step();
        iDataRead0 = '0; iDataRead1 = '0;

        // Forward priority EX > MEM > WB > RF
        prio(1'b1, 1'b1, 1'b1, 32'hAA);
        prio(1'b0, 1'b1, 1'b1, 32'hBB);
        prio(1'b0, 1'b0, 1'b1, 32'hCC);
        prio(1'b0, 1'b0, 1'b0, 32'h55);

        // Load-use on source B: one stall, one bubble, then MEM forward
        issue(5'd2, 5'd7, 1'b1, 1'b1);
        step();
        none();
        iExWe = 1'b1; iExIsLoad = 1'b1; iExAddr = 5'd7; iExData = 32'hDEAD;
        iDataRead0 = 32'h20; iDataRead1 = 32'h77;
        #1;
        check("loaduse_stall", 32'(oStall), 32'd1);
        step();
        clr_wr();
        iMemWe = 1'b1; iMemAddr = 5'd7; iMemData = 32'h1234;
        #1;
        check("loaduse_release", 32'(oStall), 32'd0);
        check("loaduse_bubble", 32'(oValid), 32'd0);
        push(32'h20, 32'h1234);
        step();
        clr_wr();
        iDataRead0 = '0; iDataRead1 = '0;

        // Zero register: EX load to r0 neither forwards nor stalls
        issue(5'd0, 5'd6, 1'b1, 1'b1);
        step();
        none();
        iExWe = 1'b1; iExIsLoad = 1'b1; iExAddr = 5'd0; iExData = 32'hFFFF;
        iDataRead0 = 32'hFFFF_FFFF; iDataRead1 = 32'h66;
        #1;
        check("r0_no_stall", 32'(oStall), 32'd0);
        push(32'h0, 32'h66);
        step();
        clr_wr();
        issue(5'd0, 5'd0, 1'b1, 1'b1);
        step();
        none();
        iExWe = 1'b1; iExAddr = 5'd0; iExData = 32'hFFFF;
        iMemWe = 1'b1; iMemAddr = 5'd0; iMemData = 32'h1;
        iWbWe = 1'b1; iWbAddr = 5'd0; iWbData = 32'h2;
        iDataRead0 = 32'h3; iDataRead1 = 32'h3;
        push(32'h0, 32'h0);
        step();
        clr_wr();
        iDataRead0 = '0; iDataRead1 = '0;

        // Hold freezes outputs for three cycles
        issue(5'd8, 5'd9, 1'b1, 1'b1);
        step();
        none();
        iDataRead0 = 32'h88; iDataRead1 = 32'h99;
        push(32'h88, 32'h99);
        step();
        iDataRead0 = 32'h1; iDataRead1 = 32'h2;
        issue(5'd10, 5'd11, 1'b1, 1'b1);
        iHold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_stall", 32'(oStall), 32'd1);
            check("hold_valid", 32'(oValid), 32'd1);
            check("hold_opA", oOpA, 32'h88);
            check("hold_opB", oOpB, 32'h99);
            step();
        end
        iHold = 1'b0;
        step();
        // Flush coincident with a load-use hazard on r10
        issue(5'd10, 5'd12, 1'b1, 1'b1);
        iExWe = 1'b1; iExIsLoad = 1'b1; iExAddr = 5'd10;
        iFlush = 1'b1;
        #1;
        check("flush_hazard_stall", 32'(oStall), 32'd1);
        step();
        iFlush = 1'b0;
        none();
        #1;
        check("flush_valid", 32'(oValid), 32'd0);
        check("flush_cvalid_cleared", 32'(oStall), 32'd0);
        step();
        clr_wr();
        #1;
        check("flush_valid_next", 32'(oValid), 32'd0);

        // Reset during a load-use stall
        issue(5'd1, 5'd2, 1'b1, 1'b1);
        step();
        issue(5'd13, 5'd14, 1'b1, 1'b1);
        iDataRead0 = 32'h101; iDataRead1 = 32'h102;
        push(32'h101, 32'h102);
        step();
        none();
        iExWe = 1'b1; iExIsLoad = 1'b1; iExAddr = 5'd13;
        iDataRead0 = 32'h5A5A; iDataRead1 = 32'hA5A5;
        #1;
        check("pre_rst_stall", 32'(oStall), 32'd1);
        check("pre_rst_valid", 32'(oValid), 32'd1);
        iRst_n = 1'b0;
        step();
        iRst_n = 1'b1;
        #1;
        check("midrst_valid", 32'(oValid), 32'd0);
        check("midrst_opA", oOpA, 32'd0);
        check("midrst_opB", oOpB, 32'd0);
        check("midrst_stall", 32'(oStall), 32'd0);
        check("midrst_cnt", oStallCnt, 32'd0);
        step();
        clr_wr();
        iDataRead0 = '0; iDataRead1 = '0;

        // Five stall cycles
        iHold = 1'b1;
        repeat (5) step();
        iHold = 1'b0;
        #1;
        check("stall_cnt", oStallCnt, STALL_EXP);

        repeat (3) step();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_operand_forward_stage
